hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  ID-stage hazard detection/stall controller for the 5-stage pipeline. Detects load-use
//  hazards and taken-branch flushes. Produces the bubble select that zeroes ID/EX control
//  (EX/MEM/WB) plus PC/IF-ID write enables and the IF/ID flush. Holds multi-cycle stalls
//  and keeps a saturating stall-cycle counter for performance monitoring.
// PARAMETERS
//  LOAD_STALLS  1   bubble cycles per load-use hazard (legal range 1..7)
//  CNT_W        16  width of stallCount
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low
//  IDEXMemRead  in   1      instruction in EX is a load
//  IDEXRt       in   5      destination register of the EX load
//  IFIDRs       in   5      rs of the instruction in ID
//  IFIDRt       in   5      rt of the instruction in ID
//  IFIDUsesRt   in   1      instruction in ID reads rt (R-type, beq, sw)
//  branchTaken  in   1      branch resolved taken this cycle
//  countClear   in   1      synchronous clear of stallCount
//  bubble       out  1      1 = zero ID/EX control fields (mux select)
//  PCWrite      out  1      1 = PC may update
//  IFIDWrite    out  1      1 = IF/ID register may update
//  IFIDFlush    out  1      1 = IF/ID loads NOP
//  stallCount   out  CNT_W  stall cycles since reset/clear, saturating
// BEHAVIOUR
//  loadUse = IDEXMemRead & (IDEXRt!=0) & (IDEXRt==IFIDRs | (IFIDUsesRt & IDEXRt==IFIDRt)).
//  FSM: IDLE, STALL. 3-bit down-counter remain.
//  Control outputs are combinational from state and inputs (zero latency: asserted in the
//  same cycle as the hazard).
//  IDLE, branchTaken=1: IFIDFlush=1, bubble=1, PCWrite=1, IFIDWrite=1; next IDLE.
//  - branchTaken has priority over loadUse (ID instruction is wrong-path).
//  IDLE, loadUse=1 (no branch): bubble=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
//  - LOAD_STALLS=1: next IDLE.
//  - LOAD_STALLS>1: next STALL with remain=LOAD_STALLS-2.
//  IDLE, neither: bubble=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
//  STALL: bubble=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0. loadUse is ignored.
//  - remain==0: next IDLE. Otherwise remain decrements.
//  STALL, branchTaken=1: abort the stall; outputs as for IDLE+branchTaken; next IDLE.
//  Total hazard stall = exactly LOAD_STALLS cycles with PCWrite=0.
//  stallCount: +1 on every clock edge where PCWrite=0 and reset is high.
//  - Saturates at all-ones; no wrap.
//  - countClear=1 sets stallCount to 0 on that edge; clear wins over increment.
//  Reset low (async, at any time incl. mid-stall): state=IDLE, remain=0, stallCount=0.
//  - While reset is low, outputs are forced: bubble=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
//  - First edge after release behaves as IDLE.
//  Back-to-back loads: a second load-use can only be detected in IDLE after the first
//  stall completes. No event is lost or double-counted.
// TESTING
//  1. lw $2 in EX, ID add rs=$2, LOAD_STALLS=1 -> 1 cycle bubble=1/PCWrite=0/IFIDWrite=0;
//     stallCount=1.
//  2. IDEXRt=0 with IFIDRs=0, MemRead=1 -> no stall. rt match with IFIDUsesRt=0 -> no stall.
//  3. LOAD_STALLS=3, load-use -> exactly 3 stall cycles, then PCWrite=1; stallCount=3.
//  4. loadUse and branchTaken in the same cycle -> IFIDFlush=1, PCWrite=1, bubble=1;
//     stallCount unchanged.
//  5. reset low during cycle 2 of a 3-cycle stall -> outputs forced immediately; after
//     release IDLE, stallCount=0.
//  6. CNT_W=4, 20 stall cycles -> stallCount holds 15. countClear=1 -> stallCount=0 next edge.

Source files
------------

// File: rtl/hazard_unit.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes and a
// saturating stall-cycle counter for performance monitoring.
module hazard_unit #(
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXRt,
  input  logic [4:0]       IFIDRs,
  input  logic [4:0]       IFIDRt,
  input  logic             IFIDUsesRt,
  input  logic             branchTaken,
  input  logic             countClear,
  output logic             bubble,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic {
    IDLE,
    STALL
  } state_e;

  // The first bubble is issued from IDLE, so STALL covers the remaining cycles.
  localparam logic [2:0] REMAIN_INIT = (LOAD_STALLS > 1) ? 3'(LOAD_STALLS - 2) : 3'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [2:0]       remain_q, remain_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load_use;

  assign load_use = IDEXMemRead && (IDEXRt != 5'd0) &&
                    ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    bubble    = 1'b0;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    state_d   = state_q;
    remain_d  = remain_q;

    if (!reset) begin
      bubble    = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (branchTaken) begin
      // Wrong-path instruction in ID: squash it, abandoning any stall in progress.
      bubble    = 1'b1;
      IFIDFlush = 1'b1;
      state_d   = IDLE;
      remain_d  = 3'd0;
    end else if (state_q == STALL) begin
      bubble    = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      if (remain_q == 3'd0) begin
        state_d = IDLE;
      end else begin
        remain_d = remain_q - 3'd1;
      end
    end else if (load_use) begin
      bubble    = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      if (LOAD_STALLS > 1) begin
        state_d  = STALL;
        remain_d = REMAIN_INIT;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (countClear) begin
      count_d = '0;
    end else if (!PCWrite && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      remain_q <= 3'd0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      count_q  <= count_d;
    end
  end

  assign stallCount = count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances cover LOAD_STALLS=1, LOAD_STALLS=3
// and a 4-bit counter, all driven from the same ID/EX stimulus.
module tb_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       IDEXMemRead;
  logic [4:0] IDEXRt;
  logic [4:0] IFIDRs;
  logic [4:0] IFIDRt;
  logic       IFIDUsesRt;
  logic       branchTaken;
  logic       countClear;

  logic        bubble1, pcw1, ifw1, flush1;
  logic [15:0] cnt1;
  logic        bubble3, pcw3, ifw3, flush3;
  logic [15:0] cnt3;
  logic        bubble4, pcw4, ifw4, flush4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  hazard_unit #(.LOAD_STALLS(1), .CNT_W(16)) u_dut1 (
    .clock(clock), .reset(reset), .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRt(IFIDUsesRt), .branchTaken(branchTaken),
    .countClear(countClear), .bubble(bubble1), .PCWrite(pcw1), .IFIDWrite(ifw1),
    .IFIDFlush(flush1), .stallCount(cnt1)
  );

  hazard_unit #(.LOAD_STALLS(3), .CNT_W(16)) u_dut3 (
    .clock(clock), .reset(reset), .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRt(IFIDUsesRt), .branchTaken(branchTaken),
    .countClear(countClear), .bubble(bubble3), .PCWrite(pcw3), .IFIDWrite(ifw3),
    .IFIDFlush(flush3), .stallCount(cnt3)
  );

  hazard_unit #(.LOAD_STALLS(1), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRt(IFIDUsesRt), .branchTaken(branchTaken),
    .countClear(countClear), .bubble(bubble4), .PCWrite(pcw4), .IFIDWrite(ifw4),
    .IFIDFlush(flush4), .stallCount(cnt4)
  );

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_quiet();
    IDEXMemRead = 1'b0;
    IDEXRt      = 5'd0;
    IFIDRs      = 5'd0;
    IFIDRt      = 5'd0;
    IFIDUsesRt  = 1'b0;
    branchTaken = 1'b0;
    countClear  = 1'b0;
  endtask

  task automatic drive_load_use();
    IDEXMemRead = 1'b1;
    IDEXRt      = 5'd2;
    IFIDRs      = 5'd2;
    IFIDRt      = 5'd7;
    IFIDUsesRt  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive_quiet();
    settle();

    // Reset asserted: outputs forced to stall values, counter cleared.
    check("rst_bubble", bubble1, 1);
    check("rst_pcwrite", pcw1, 0);
    check("rst_ifidwrite", ifw1, 0);
    check("rst_flush", flush1, 0);
    check("rst_count", cnt1, 0);
    tick();
    tick();
    check("rst_count_held", cnt3, 0);

    @(negedge clock);
    reset = 1'b1;
    tick();
    check("idle_pcwrite", pcw1, 1);
    check("idle_bubble", bubble1, 0);
    check("idle_count", cnt1, 0);

    // 1. Single load-use hazard, rs match.
    drive_load_use();
    settle();
    check("lu_bubble1", bubble1, 1);
    check("lu_pcwrite1", pcw1, 0);
    check("lu_ifidwrite1", ifw1, 0);
    check("lu_flush1", flush1, 0);
    check("lu_pcwrite3", pcw3, 0);
    tick();
    drive_quiet();
    settle();
    check("lu_done_pcwrite1", pcw1, 1);
    check("lu_count1", cnt1, 1);
    check("lu3_c2_pcwrite", pcw3, 0);
    check("lu3_c2_bubble", bubble3, 1);
    tick();
    check("lu3_c3_pcwrite", pcw3, 0);
    check("lu3_c3_count", cnt3, 2);
    tick();
    check("lu3_done_pcwrite", pcw3, 1);
    check("lu3_count", cnt3, 3);
    check("lu_count1_stable", cnt1, 1);

    // 2. No-hazard corner cases, then the rt path with IFIDUsesRt.
    IDEXMemRead = 1'b1;
    IDEXRt      = 5'd0;
    IFIDRs      = 5'd0;
    settle();
    check("r0_no_stall", pcw1, 1);
    IDEXRt     = 5'd5;
    IFIDRs     = 5'd3;
    IFIDRt     = 5'd5;
    IFIDUsesRt = 1'b0;
    settle();
    check("rt_unused_no_stall", pcw1, 1);
    IFIDUsesRt = 1'b1;
    settle();
    check("rt_used_stall", pcw1, 0);
    IDEXMemRead = 1'b0;
    settle();
    check("no_load_no_stall", pcw1, 1);
    drive_quiet();

    // 4. Branch wins over a simultaneous load-use.
    drive_load_use();
    branchTaken = 1'b1;
    settle();
    check("br_flush", flush1, 1);
    check("br_pcwrite", pcw1, 1);
    check("br_bubble", bubble1, 1);
    check("br_ifidwrite", ifw1, 1);
    tick();
    drive_quiet();
    settle();
    check("br_count1", cnt1, 1);
    check("br_count3", cnt3, 3);
    check("br_idle3", pcw3, 1);

    // Branch aborting a stall already in progress (LOAD_STALLS=3).
    drive_load_use();
    tick();
    drive_quiet();
    branchTaken = 1'b1;
    settle();
    check("abort_flush3", flush3, 1);
    check("abort_pcwrite3", pcw3, 1);
    check("abort_bubble3", bubble3, 1);
    tick();
    branchTaken = 1'b0;
    settle();
    check("abort_idle3", pcw3, 1);
    check("abort_count3", cnt3, 4);
    check("abort_count1", cnt1, 2);

    // 5. Reset in the middle of a 3-cycle stall.
    countClear = 1'b1;
    tick();
    countClear = 1'b0;
    settle();
    check("clr_count3", cnt3, 0);
    drive_load_use();
    tick();
    drive_quiet();
    settle();
    check("mid_pcwrite3", pcw3, 0);
    check("mid_count3", cnt3, 1);
    #2;
    reset = 1'b0;
    settle();
    check("mid_rst_pcwrite3", pcw3, 0);
    check("mid_rst_bubble3", bubble3, 1);
    check("mid_rst_ifidwrite3", ifw3, 0);
    check("mid_rst_count3", cnt3, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("post_rst_pcwrite3", pcw3, 1);
    check("post_rst_bubble3", bubble3, 0);
    check("post_rst_count3", cnt3, 0);

    // 6. Saturation of the 4-bit counter, then clear winning over increment.
    drive_load_use();
    for (int i = 0; i < 20; i++) tick();
    check("sat_count4", cnt4, 15);
    check("sat_count1", cnt1, 20);
    check("sat_count3", cnt3, 20);
    countClear = 1'b1;
    tick();
    check("clr_wins_count4", cnt4, 0);
    check("clr_wins_count1", cnt1, 0);
    countClear = 1'b0;
    tick();
    check("post_clr_count4", cnt4, 1);
    drive_quiet();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
